keypad_time_entry: RTL and testbench
====================================

# keypad_time_entry

Scans a 4x4 matrix keypad and turns debounced key presses into a committed alarm/clock time value. Converts entered BCD digits HH:MM into binary hours and minutes so its output connects directly to the 16-bit binary display input and the time registers of the alarm clock. Row strobing mirrors the display's anode scanning, in the input direction.

## Interface
- SCAN_DIV, 5000: clk cycles per row dwell (20 kHz row rate at 100 MHz); >= 2
- DEB_SCANS, 4: consecutive identical full scans required before a key code is accepted; 1..15
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- col  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- row  out  4  keypad row drive, active-low, exactly one row low at a time
- digits  out  16  BCD entry in progress {H10,H1,M10,M1}
- time_bin  out  16  committed time {hours[7:0], minutes[7:0]}, binary
- valid  out  1  one-cycle pulse when time_bin updates
- err  out  1  one-cycle pulse when a commit is rejected
- entry_active  out  1  high while digit count is nonzero

## Operation
- col passes through a 2-flop synchronizer before use.
- Row scan: dwell counter 0..SCAN_DIV-1. At terminal count, row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110. Columns are sampled on the terminal-count cycle of each dwell, before the rotation.
- Per scan (4 dwells) a scan code is built: NONE if no column low in any row; KEY(code) if exactly one column low in exactly one row; MULTI otherwise. MULTI is treated as NONE for debounce purposes.
- Key map, row r / column c -> code: r0: 1,2,3,A(10); r1: 4,5,6,B(11); r2: 7,8,9,C(12); r3: *(14),0,#(15),D(13).
- Debounce: at end of each scan, compare with previous scan code; equal -> stable count +1 (saturating at 15), else 0. When stable count reaches DEB_SCANS with KEY and the detector is armed -> one key event, disarm. When NONE is stable DEB_SCANS -> re-arm. No auto-repeat.
- Entry FSM, states IDLE (count 0) and ENTRY (count 1..4):
  - digit 0-9: if count < 4, digits <= {digits[11:0], d}, count+1; 5th and later digits ignored.
  - * : digits <= 0, count <= 0, go IDLE.
  - # : validate H = 10*H10+H1 <= 23 and M = 10*M10+M1 <= 59. Pass -> time_bin <= {H, M}, valid pulse. Fail -> err pulse, time_bin unchanged. Either way digits <= 0, count <= 0, IDLE. # in IDLE commits 00:00 (valid).
  - A-D: ignored.
- Fewer than 4 digits before # are right-aligned (left zero-padded) by the shift.
- Arithmetic: each product is 8 bits wide, no overflow for legal BCD. Digits above 9 never enter the register.

## Timing
- Reset values: row=1110, dwell counter=0, digits=0, time_bin=0, valid=0, err=0, entry_active=0, debounce armed, previous scan code NONE, stable count 0.
- Scan period = 4*SCAN_DIV cycles. Press-to-event latency is DEB_SCANS to DEB_SCANS+1 scans, plus 2 synchronizer cycles.
- The key event is internal and single-cycle. digits, time_bin, valid and err update on the clk edge after the event. valid and err are high for exactly one cycle and never both.
- An asserted rst clears all state immediately, including mid-entry and mid-debounce. After release, scanning restarts at row 0.
- A key held across rst produces a new event after release (detector re-armed).

## Configuration
- KTE_AUTOCOMMIT_EN defined: the digit that makes count 4 also triggers validation and commit in the same event, with behaviour identical to #. # then behaves as in IDLE only when count is 0; otherwise it commits the partial entry.
- KTE_AUTOCOMMIT_EN undefined: only # commits, and 5th+ digits are ignored as above.

## Test plan
- SCAN_DIV=4, DEB_SCANS=2; press 1,2,3,0,# -> digits steps 0001,0012,0123,1230; time_bin=0x0C1E, one valid pulse, digits=0.
- Enter 2,4,0,0,# -> err pulse, time_bin keeps its previous value, valid stays 0.
- Key 5 bouncing (toggles every dwell for 3 scans, then stable) -> exactly one event, digits=0005. Holding key 5 for 20 scans -> no further events.
- Keys 1 and 5 held together (MULTI) -> no event. Enter 9,*,0,7,# -> time_bin=0x0007.
- rst pulsed after entering 1,2 -> all outputs at reset values; next entry 0,5,3,0,# -> time_bin=0x051E.
- KTE_AUTOCOMMIT_EN defined: enter 0,8,4,5 with no # -> valid one cycle after the 4th event, time_bin=0x082D.

Source files
------------

// File: rtl/keypad_time_entry_if.sv
// Keypad pins and time-entry results of keypad_time_entry, bundled as one port.
// master = the scanner/entry block, slave = the keypad/consumer side.
interface keypad_time_entry_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] digits;
    logic [15:0] time_bin;
    logic        valid;
    logic        err;
    logic        entry_active;

    modport master (input col, output row, digits, time_bin, valid, err, entry_active);
    modport slave  (output col, input row, digits, time_bin, valid, err, entry_active);
endinterface

// File: rtl/keypad_time_entry.sv
// 4x4 keypad scanner with scan-level debounce and HH:MM entry/commit to binary time.
// Optional KTE_AUTOCOMMIT_EN: the 4th digit commits immediately, as if # followed it.
module keypad_time_entry #(
    parameter int SCAN_DIV  = 5000,
    parameter int DEB_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    keypad_time_entry_if.master kp
);
    localparam int              CW         = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N      = 4'(DEB_SCANS);
    localparam logic [3:0]      K_STAR     = 4'd14;
    localparam logic [3:0]      K_HASH     = 4'd15;

    typedef enum logic {IDLE, ENTRY} state_t;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'd0;
        case ({r, c})
            4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = 4'd10;
            4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = 4'd11;
            4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = 4'd12;
            4'hC: k = 4'd14;  4'hD: k = 4'd0;   4'hE: k = 4'd15;  4'hF: k = 4'd13;
            default: k = 4'd0;
        endcase
        return k;
    endfunction

    logic [3:0]    col_s1_q, col_s2_q;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic          acc_key_q, acc_key_d, acc_multi_q, acc_multi_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [4:0]    prev_code_q, prev_code_d;    // {is_key, code}; 0 means NONE
    logic [3:0]    stable_q, stable_d;
    logic          armed_q, armed_d;
    logic          evt_q, evt_d;
    logic [3:0]    evt_code_q, evt_code_d;
    state_t        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [15:0]   digits_q, digits_d;
    logic [15:0]   time_q, time_d;
    logic          valid_q, valid_d, err_q, err_d;

    logic [3:0]    col_low;
    logic [3:0]    col_code [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign col_low[gi]  = ~col_s2_q[gi];
        assign col_code[gi] = keymap(row_idx_q, 2'(gi));
    end

    // Scan accumulation and debounce
    logic       tc;
    logic [2:0] row_hits;
    logic [3:0] row_code;
    logic       acc_key_n, acc_multi_n;
    logic [3:0] acc_code_n;
    logic [4:0] scan_code;
    logic [3:0] stable_n;

    always_comb begin
        row_hits = 3'd0;
        row_code = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (col_low[i]) begin
                row_hits = row_hits + 3'd1;
                row_code = col_code[i];
            end
        end

        acc_key_n   = acc_key_q;
        acc_multi_n = acc_multi_q;
        acc_code_n  = acc_code_q;
        if (row_hits == 3'd1 && !acc_key_q && !acc_multi_q) begin
            acc_key_n  = 1'b1;
            acc_code_n = row_code;
        end else if (row_hits != 3'd0) begin
            acc_multi_n = 1'b1;
        end

        tc          = (dwell_q == DWELL_LAST);
        dwell_d     = dwell_q + 1'b1;
        row_idx_d   = row_idx_q;
        acc_key_d   = acc_key_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        armed_d     = armed_q;
        evt_d       = 1'b0;
        evt_code_d  = evt_code_q;
        scan_code   = 5'd0;
        stable_n    = stable_q;

        if (tc) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
            if (row_idx_q == 2'd3) begin
                // MULTI collapses to NONE so a chord can never produce an event
                scan_code = (acc_key_n && !acc_multi_n) ? {1'b1, acc_code_n} : 5'd0;
                if (scan_code == prev_code_q)
                    stable_n = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
                else
                    stable_n = 4'd0;
                stable_d    = stable_n;
                prev_code_d = scan_code;
                acc_key_d   = 1'b0;
                acc_multi_d = 1'b0;
                acc_code_d  = 4'd0;
                if (stable_n >= DEB_N) begin
                    if (scan_code[4]) begin
                        if (armed_q) begin
                            evt_d      = 1'b1;
                            evt_code_d = scan_code[3:0];
                            armed_d    = 1'b0;
                        end
                    end else begin
                        armed_d = 1'b1;
                    end
                end
            end else begin
                acc_key_d   = acc_key_n;
                acc_multi_d = acc_multi_n;
                acc_code_d  = acc_code_n;
            end
        end
    end

    // Entry FSM and commit validation
    logic        commit;
    logic [15:0] commit_val;
    logic [15:0] shifted;
    logic [7:0]  hours, mins;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        digits_d   = digits_q;
        time_d     = time_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        commit     = 1'b0;
        commit_val = digits_q;
        shifted    = {digits_q[11:0], evt_code_q};

        if (evt_q) begin
            if (evt_code_q <= 4'd9) begin
                if (count_q < 3'd4) begin
                    digits_d = shifted;
                    count_d  = count_q + 3'd1;
                    state_d  = ENTRY;
`ifdef KTE_AUTOCOMMIT_EN
                    if (count_q == 3'd3) begin
                        commit     = 1'b1;
                        commit_val = shifted;
                    end
`endif
                end
            end else if (evt_code_q == K_STAR) begin
                digits_d = 16'd0;
                count_d  = 3'd0;
                state_d  = IDLE;
            end else if (evt_code_q == K_HASH) begin
                commit = 1'b1;
            end
        end

        hours = {4'd0, commit_val[15:12]} * 8'd10 + {4'd0, commit_val[11:8]};
        mins  = {4'd0, commit_val[7:4]}   * 8'd10 + {4'd0, commit_val[3:0]};

        if (commit) begin
            if (hours <= 8'd23 && mins <= 8'd59) begin
                time_d  = {hours, mins};
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            digits_d = 16'd0;
            count_d  = 3'd0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            dwell_q     <= '0;
            row_idx_q   <= 2'd0;
            acc_key_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
            prev_code_q <= 5'd0;
            stable_q    <= 4'd0;
            armed_q     <= 1'b1;
            evt_q       <= 1'b0;
            evt_code_q  <= 4'd0;
            state_q     <= IDLE;
            count_q     <= 3'd0;
            digits_q    <= 16'd0;
            time_q      <= 16'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            col_s1_q    <= kp.col;
            col_s2_q    <= col_s1_q;
            dwell_q     <= dwell_d;
            row_idx_q   <= row_idx_d;
            acc_key_q   <= acc_key_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            armed_q     <= armed_d;
            evt_q       <= evt_d;
            evt_code_q  <= evt_code_d;
            state_q     <= state_d;
            count_q     <= count_d;
            digits_q    <= digits_d;
            time_q      <= time_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign kp.row          = ~(4'b0001 << row_idx_q);
    assign kp.digits       = digits_q;
    assign kp.time_bin     = time_q;
    assign kp.valid        = valid_q;
    assign kp.err          = err_q;
    assign kp.entry_active = (state_q == ENTRY);
endmodule

// File: tb/tb_keypad_time_entry.sv
// Randomized keypad sessions checked against a digit-list model of the entry rules.
`timescale 1ns/1ps
module tb_keypad_time_entry;
    localparam int SD   = 4;
    localparam int DEB  = 2;
    localparam int SCAN = 4 * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_time_entry_if kif ();
    keypad_time_entry #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    // Keypad: a pressed key shorts its column low while its row is driven low
    logic [15:0] pressed = '0;
    logic [3:0]  col_drv;
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kif.row[r] && pressed[r*4+c]) col_drv[c] = 1'b0;
    end
    assign kif.col = col_drv;

    // Position r*4+c of each key code 0..15
    int key_pos [16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk2(input string name, input logic [15:0] act, input logic [15:0] a, input logic [15:0] b);
        checks++;
        if (act !== a && act !== b) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h or 0x%0h", name, act, a, b);
        end
    endfunction

    // Model: the list of entered digits and the last committed time
    int          dq[$];
    logic [15:0] m_time = 16'd0;

    function automatic logic [15:0] model_digits();
        logic [15:0] v;
        v = 16'd0;
        foreach (dq[i]) v = (v << 4) | 16'(dq[i]);
        return v;
    endfunction

    task automatic model_commit(output int nv, output int ne);
        int d[4];
        int h, m;
        for (int i = 0; i < 4; i++) d[i] = 0;
        for (int i = 0; i < dq.size(); i++) d[4 - dq.size() + i] = dq[i];
        h = 10 * d[0] + d[1];
        m = 10 * d[2] + d[3];
        if (h <= 23 && m <= 59) begin
            m_time = 16'(h * 256 + m);
            nv = 1; ne = 0;
        end else begin
            nv = 0; ne = 1;
        end
        dq.delete();
    endtask

    task automatic model_step(input int code, output int nv, output int ne);
        nv = 0; ne = 0;
        if (code <= 9) begin
            if (dq.size() < 4) begin
                dq.push_back(code);
`ifdef KTE_AUTOCOMMIT_EN
                if (dq.size() == 4) model_commit(nv, ne);
`endif
            end
        end else if (code == 14) begin
            dq.delete();
        end else if (code == 15) begin
            model_commit(nv, ne);
        end
    endtask

    // Expectations for the current press window
    logic [15:0] pre_dig, post_dig, pre_time, post_time;
    logic        post_act;
    int          exp_v, exp_e, seen_v, seen_e;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("row_one_low", 32'($countones(~kif.row)), 32'd1);
            chk("valid_err_exclusive", 32'(kif.valid & kif.err), 32'd0);
            chk2("digits_track", kif.digits, pre_dig, post_dig);
            chk2("time_track", kif.time_bin, pre_time, post_time);
            if (kif.valid) begin
                seen_v++;
                chk("valid_time", kif.time_bin, post_time);
            end
            if (kif.err) begin
                seen_e++;
                chk("err_time_kept", kif.time_bin, pre_time);
            end
        end
    end

    task automatic expect_key(input int code);
        pre_dig  = model_digits();
        pre_time = m_time;
        model_step(code, exp_v, exp_e);
        post_dig  = model_digits();
        post_time = m_time;
        post_act  = (dq.size() != 0);
    endtask

    task automatic expect_none();
        pre_dig  = model_digits();
        pre_time = m_time;
        post_dig  = pre_dig;
        post_time = pre_time;
        post_act  = (dq.size() != 0);
        exp_v = 0; exp_e = 0;
    endtask

    task automatic finish_window();
        @(negedge clk);
        mon_en = 1'b0;
        chk("valid_count", 32'(seen_v), 32'(exp_v));
        chk("err_count", 32'(seen_e), 32'(exp_e));
        chk("digits", kif.digits, post_dig);
        chk("time_bin", kif.time_bin, post_time);
        chk("entry_active", kif.entry_active, post_act);
    endtask

    task automatic run_window(input logic [15:0] mask, input int bounce_dwells, input int hold_scans, input int rel_scans);
        seen_v = 0; seen_e = 0; mon_en = 1'b1;
        for (int i = 0; i < bounce_dwells; i++) begin
            pressed = pressed ^ mask;
            repeat (SD) @(posedge clk);
        end
        pressed = mask;
        repeat (hold_scans * SCAN) @(posedge clk);
        pressed = '0;
        repeat (rel_scans * SCAN) @(posedge clk);
        finish_window();
    endtask

    task automatic do_key(input int code);
        expect_key(code);
        run_window(16'(1) << key_pos[code], 0, 6, 6);
        $display("key %0d: digits=%04h time_bin=%04h valid=%0d err=%0d", code, kif.digits, kif.time_bin, seen_v, seen_e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_row"}, kif.row, 4'b1110);
        chk({tag, "_digits"}, kif.digits, 16'h0000);
        chk({tag, "_time_bin"}, kif.time_bin, 16'h0000);
        chk({tag, "_valid"}, kif.valid, 1'b0);
        chk({tag, "_err"}, kif.err, 1'b0);
        chk({tag, "_entry_active"}, kif.entry_active, 1'b0);
    endtask

    task automatic pulse_reset();
        mon_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        dq.delete();
        m_time = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("in_reset");
        rst = 1'b0;
        $display("reset pulse applied");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

`ifndef KTE_AUTOCOMMIT_EN
        do_key(1); chk("step1", kif.digits, 16'h0001);
        do_key(2); chk("step2", kif.digits, 16'h0012);
        do_key(3); chk("step3", kif.digits, 16'h0123);
        do_key(0); chk("step4", kif.digits, 16'h1230);
        do_key(15); chk("commit_0C1E", kif.time_bin, 16'h0C1E);
        chk("commit_digits_clear", kif.digits, 16'h0000);
        do_key(2); do_key(4); do_key(0); do_key(0);
        do_key(15); chk("bad_time_kept", kif.time_bin, 16'h0C1E);
`else
        do_key(0); do_key(8); do_key(4);
        do_key(5); chk("auto_082D", kif.time_bin, 16'h082D);
        chk("auto_digits_clear", kif.digits, 16'h0000);
        do_key(2); do_key(4); do_key(0);
        do_key(0); chk("auto_bad_kept", kif.time_bin, 16'h082D);
`endif

        // Bouncing key 5, then held for 20 more scans: one event only
        expect_key(5);
        run_window(16'(1) << key_pos[5], 12, 26, 6);
        chk("bounce_0005", kif.digits, 16'h0005);
        $display("bounce key 5: digits=%04h", kif.digits);

        // Two keys together never produce an event
        expect_none();
        run_window((16'(1) << key_pos[1]) | (16'(1) << key_pos[5]), 0, 8, 6);
        $display("multi 1+5: digits=%04h", kif.digits);
        do_key(9); do_key(14); do_key(0); do_key(7);
        do_key(15); chk("commit_0007", kif.time_bin, 16'h0007);

        // Reset mid-entry
        do_key(1); do_key(2);
        pulse_reset();
        do_key(0); do_key(5); do_key(3); do_key(0);
`ifndef KTE_AUTOCOMMIT_EN
        do_key(15);
`endif
        chk("commit_051E", kif.time_bin, 16'h051E);

        // Key held across reset yields a fresh event afterwards
        expect_key(3);
        seen_v = 0; seen_e = 0; mon_en = 1'b1;
        pressed = 16'(1) << key_pos[3];
        repeat (6 * SCAN) @(posedge clk);
        pulse_reset();
        expect_key(3);
        seen_v = 0; seen_e = 0; mon_en = 1'b1;
        repeat (6 * SCAN) @(posedge clk);
        pressed = '0;
        repeat (6 * SCAN) @(posedge clk);
        finish_window();
        chk("held_across_reset", kif.digits, 16'h0003);
        $display("held across reset: digits=%04h", kif.digits);
        do_key(14);

        // Random key sequences
        for (int n = 0; n < 60; n++) begin
            int r;
            int code;
            r = int'($urandom_range(0, 19));
            if (r < 12)      code = r % 10;
            else if (r < 15) code = 15;
            else if (r < 16) code = 14;
            else             code = r - 6;
            do_key(code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
